agc_timing_generator: RTL and testbench
=======================================

// Module: agc_timing_generator
// PURPOSE
//  Parametrised successor of the timer: derives phase, timepulse and memory-cycle timing from the slow CLOCK oscillator.
//  Synchronises CLOCK into the SIM_CLK domain, counts phases within timepulses and timepulses within a memory cycle (MCT).
//  Emits one-SIM_CLK strobes (RT, WT, CT) at configurable phases.
//  Adds STOP-at-boundary and single-MCT step modes; feeds the control-pulse and memory timing logic.
// PARAMETERS
//  SYNC_STAGES  2   flops in CLOCK synchroniser (>=2)
//  NUM_PHASES   4   phases per timepulse (>=2)
//  NUM_TP       12  timepulses per MCT (>=2)
//  RT_PHASE     1   phase index on whose entry RT pulses (<NUM_PHASES)
//  WT_PHASE     2   phase index on whose entry WT pulses
//  CT_PHASE     3   phase index on whose entry CT pulses (RT/WT/CT indices distinct)
// PORTS
//  SIM_CLK    in   1           simulation clock, all state on rising edge
//  SIM_RST    in   1           asynchronous, active-high reset
//  CLOCK      in   1           oscillator, asynchronous to SIM_CLK, period >> SIM_CLK
//  STOP       in   1           level: halt at next timepulse boundary
//  STEP_MODE  in   1           level: halt at every MCT boundary
//  MSTEP      in   1           SIM_CLK-synchronous pulse: run one MCT while halted in step mode
//  PHASE      out  NUM_PHASES  one-hot current phase
//  TP         out  NUM_TP      one-hot current timepulse
//  RT, WT, CT out  1           one-SIM_CLK strobes
//  MCT_END    out  1           one-SIM_CLK strobe on MCT wrap
//  ODDSET     out  1           high during odd MCTs
//  EVNSET     out  1           ~ODDSET
//  RUNNING    out  1           1 in RUN, 0 in HALT
// BEHAVIOUR
//  Reset (async, immediate): sync flops 0; phase_idx=0, tp_idx=0 (PHASE=1, TP=1); RT=WT=CT=MCT_END=0; ODDSET=0, EVNSET=1; state=RUN, RUNNING=1.
//  tick = rising edge of synchronised CLOCK (last sync flop 0->1); latency CLOCK edge -> tick = SYNC_STAGES+1 SIM_CLK cycles.
//  Counters: phase_idx width $clog2(NUM_PHASES), tp_idx width $clog2(NUM_TP); explicit wrap at NUM_PHASES-1 / NUM_TP-1 (no power-of-2 reliance).
//  PHASE/TP are registered decodes of the counters, exactly one bit set at all times.
//  State RUN, on tick: phase_idx++; wrap -> phase_idx=0, tp_idx++; tp wrap -> tp_idx=0, MCT_END=1, ODDSET toggles.
//   Strobe X (RT/WT/CT) =1 for the single SIM_CLK cycle after the tick whose new phase_idx==X_PHASE; 0 otherwise.
//   Timepulse boundary = tick wrapping phase to 0. If STOP=1 at that tick, advance normally then enter HALT.
//   MCT boundary = tick wrapping tp to 0. If STEP_MODE=1 at that tick, advance then enter HALT.
//  State HALT: counters frozen, no strobes, RUNNING=0; ticks ignored except as below.
//   STEP_MODE=0 and STOP=0 at a tick -> RUN; that tick itself does not advance (first advance on next tick).
//   STEP_MODE=1: MSTEP=1 -> RUN, registered; runs to next MCT boundary then HALT again (STEP_MODE still 1).
//  MSTEP in RUN: ignored (not queued). MSTEP with STEP_MODE=0: ignored.
//  STOP and STEP_MODE both at MCT boundary: single HALT entry, MCT_END still pulses.
//  STOP deasserted before boundary: no halt. STOP toggling between ticks: only value at tick matters.
//  Reset mid-MCT or in HALT: returns to reset state; any pulse in flight is dropped.
//  CLOCK high at reset release: no tick until it falls and rises again.
// TESTING
//  Reset, CLOCK running, defaults -> PHASE 0001->0010 on tick 1, RT=1 one cycle; WT at tick 2, CT at tick 3; TP=0x002 at tick 4.
//  48 ticks -> MCT_END single pulse, TP=0x001, PHASE=0001, ODDSET 0->1; 96 ticks -> ODDSET back to 0.
//  STOP=1 raised at tick 5 -> halts after tick 8 with TP=0x004, PHASE=0001, RUNNING=0; STOP=0 -> resumes, 1st advance on 2nd tick after release.
//  STEP_MODE=1 -> halt at tick 48; MSTEP pulse -> exactly 48 further ticks counted, one MCT_END, halt again; MSTEP during run ignored.
//  SIM_RST asserted mid-strobe (CT high, TP=0x020) -> all outputs to reset values same cycle, no strobe after release until first tick.
//  NUM_PHASES=3, NUM_TP=5, CT_PHASE=2 -> MCT_END every 15 ticks, counters never exceed 2/4, one-hot preserved.

Source files
------------

// File: rtl/agc_timing_generator.sv
// Phase / timepulse / memory-cycle timing generator driven by the slow CLOCK oscillator.
// CLOCK is synchronised into SIM_CLK; each synchronised rising edge advances the phase counter.
module agc_timing_generator #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_PHASES  = 4,
    parameter int NUM_TP      = 12,
    parameter int RT_PHASE    = 1,
    parameter int WT_PHASE    = 2,
    parameter int CT_PHASE    = 3
) (
    input  logic                  SIM_CLK,
    input  logic                  SIM_RST,
    input  logic                  CLOCK,
    input  logic                  STOP,
    input  logic                  STEP_MODE,
    input  logic                  MSTEP,
    output logic [NUM_PHASES-1:0] PHASE,
    output logic [NUM_TP-1:0]     TP,
    output logic                  RT,
    output logic                  WT,
    output logic                  CT,
    output logic                  MCT_END,
    output logic                  ODDSET,
    output logic                  EVNSET,
    output logic                  RUNNING
);

    localparam int PW = $clog2(NUM_PHASES);
    localparam int TW = $clog2(NUM_TP);
    localparam logic [PW-1:0] PHASE_LAST = PW'(NUM_PHASES - 1);
    localparam logic [TW-1:0] TP_LAST    = TW'(NUM_TP - 1);
    localparam logic [PW-1:0] RT_IDX     = PW'(RT_PHASE);
    localparam logic [PW-1:0] WT_IDX     = PW'(WT_PHASE);
    localparam logic [PW-1:0] CT_IDX     = PW'(CT_PHASE);

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   sync_prev;
    logic                   armed;
    logic                   tick;

    logic [PW-1:0] phase_idx, phase_n;
    logic [TW-1:0] tp_idx, tp_n;
    logic          phase_wrap, tp_wrap;
    logic          rt_n, wt_n, ct_n, mct_n, odd_n;

    // fill_q marks when the last sync stage carries a real CLOCK sample; a tick needs a low seen first,
    // so CLOCK already high at reset release does not count as an edge.
    assign tick = sync_q[SYNC_STAGES-1] & ~sync_prev & armed;

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            sync_q    <= '0;
            fill_q    <= '0;
            sync_prev <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], CLOCK};
            fill_q    <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            sync_prev <= sync_q[SYNC_STAGES-1];
            armed     <= armed | (fill_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-1]);
        end
    end

    always_comb begin
        state_n    = state;
        phase_n    = phase_idx;
        tp_n       = tp_idx;
        rt_n       = 1'b0;
        wt_n       = 1'b0;
        ct_n       = 1'b0;
        mct_n      = 1'b0;
        odd_n      = ODDSET;
        phase_wrap = (phase_idx == PHASE_LAST);
        tp_wrap    = phase_wrap && (tp_idx == TP_LAST);

        case (state)
            ST_RUN: begin
                if (tick) begin
                    phase_n = phase_wrap ? '0 : phase_idx + 1'b1;
                    if (phase_wrap) begin
                        tp_n = tp_wrap ? '0 : tp_idx + 1'b1;
                    end
                    rt_n  = (phase_n == RT_IDX);
                    wt_n  = (phase_n == WT_IDX);
                    ct_n  = (phase_n == CT_IDX);
                    mct_n = tp_wrap;
                    if (tp_wrap) begin
                        odd_n = ~ODDSET;
                    end
                    if ((tp_wrap && STEP_MODE) || (phase_wrap && STOP)) begin
                        state_n = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                // Step mode resumes only on MSTEP; otherwise a tick with STOP low resumes without advancing.
                if (STEP_MODE) begin
                    if (MSTEP) begin
                        state_n = ST_RUN;
                    end
                end else if (tick && !STOP) begin
                    state_n = ST_RUN;
                end
            end
            default: state_n = ST_RUN;
        endcase
    end

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            state     <= ST_RUN;
            phase_idx <= '0;
            tp_idx    <= '0;
            PHASE     <= NUM_PHASES'(1);
            TP        <= NUM_TP'(1);
            RT        <= 1'b0;
            WT        <= 1'b0;
            CT        <= 1'b0;
            MCT_END   <= 1'b0;
            ODDSET    <= 1'b0;
        end else begin
            state     <= state_n;
            phase_idx <= phase_n;
            tp_idx    <= tp_n;
            PHASE     <= NUM_PHASES'(1) << phase_n;
            TP        <= NUM_TP'(1) << tp_n;
            RT        <= rt_n;
            WT        <= wt_n;
            CT        <= ct_n;
            MCT_END   <= mct_n;
            ODDSET    <= odd_n;
        end
    end

    assign EVNSET  = ~ODDSET;
    assign RUNNING = (state == ST_RUN);

endmodule

// File: tb/tb_agc_timing_generator.sv
// Self-checking bench: default-config DUT against a tick-count model, plus a 3-phase/5-TP instance.
module tb_agc_timing_generator;

    logic SIM_CLK = 1'b0;
    logic SIM_RST = 1'b0;
    logic CLOCK = 1'b0;
    logic STOP = 1'b0;
    logic STEP_MODE = 1'b0;
    logic MSTEP = 1'b0;

    logic [3:0]  PHASE;
    logic [11:0] TP;
    logic RT, WT, CT, MCT_END, ODDSET, EVNSET, RUNNING;

    logic stop2 = 1'b0;
    logic step2 = 1'b0;
    logic mstep2 = 1'b0;
    logic [2:0] phase2;
    logic [4:0] tp2;
    logic rt2, wt2, ct2, mct2, odd2, evn2, run2;

    agc_timing_generator dut (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .CLOCK(CLOCK), .STOP(STOP),
        .STEP_MODE(STEP_MODE), .MSTEP(MSTEP), .PHASE(PHASE), .TP(TP),
        .RT(RT), .WT(WT), .CT(CT), .MCT_END(MCT_END), .ODDSET(ODDSET),
        .EVNSET(EVNSET), .RUNNING(RUNNING)
    );

    agc_timing_generator #(
        .NUM_PHASES(3), .NUM_TP(5), .RT_PHASE(0), .WT_PHASE(1), .CT_PHASE(2)
    ) dut2 (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .CLOCK(CLOCK), .STOP(stop2),
        .STEP_MODE(step2), .MSTEP(mstep2), .PHASE(phase2), .TP(tp2),
        .RT(rt2), .WT(wt2), .CT(ct2), .MCT_END(mct2), .ODDSET(odd2),
        .EVNSET(evn2), .RUNNING(run2)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    int total = 0;
    int bad = 0;

    // Model: count of advancing ticks; every output follows from it by division/modulo.
    int adv, adv2;
    bit halted;
    bit e_rt, e_wt, e_ct, e_mct;
    bit e2_rt, e2_wt, e2_ct, e2_mct;

    logic [3:0]  snap_phase;
    logic [11:0] snap_tp;
    logic snap_rt, snap_wt, snap_ct, snap_mct, snap_odd, snap_run;

    typedef struct {
        logic [3:0]  phase;
        logic [11:0] tp;
        logic        rt;
        logic        wt;
        logic        ct;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit sc);
        chk({tag, ".PHASE"},   int'(PHASE),   1 << (adv % 4));
        chk({tag, ".TP"},      int'(TP),      1 << ((adv / 4) % 12));
        chk({tag, ".RT"},      int'(RT),      int'(sc & e_rt));
        chk({tag, ".WT"},      int'(WT),      int'(sc & e_wt));
        chk({tag, ".CT"},      int'(CT),      int'(sc & e_ct));
        chk({tag, ".MCT_END"}, int'(MCT_END), int'(sc & e_mct));
        chk({tag, ".ODDSET"},  int'(ODDSET),  (adv / 48) % 2);
        chk({tag, ".EVNSET"},  int'(EVNSET),  1 - ((adv / 48) % 2));
        chk({tag, ".RUNNING"}, int'(RUNNING), int'(!halted));
        chk({tag, ".phase2"},  int'(phase2),  1 << (adv2 % 3));
        chk({tag, ".tp2"},     int'(tp2),     1 << ((adv2 / 3) % 5));
        chk({tag, ".rt2"},     int'(rt2),     int'(sc & e2_rt));
        chk({tag, ".wt2"},     int'(wt2),     int'(sc & e2_wt));
        chk({tag, ".ct2"},     int'(ct2),     int'(sc & e2_ct));
        chk({tag, ".mct2"},    int'(mct2),    int'(sc & e2_mct));
        chk({tag, ".odd2"},    int'(odd2),    (adv2 / 15) % 2);
        chk({tag, ".onehot2"}, int'($onehot(phase2) && $onehot(tp2)), 1);
    endtask

    task automatic model_tick();
        e_rt = 0; e_wt = 0; e_ct = 0; e_mct = 0;
        if (!halted) begin
            adv++;
            e_rt  = (adv % 4 == 1);
            e_wt  = (adv % 4 == 2);
            e_ct  = (adv % 4 == 3);
            e_mct = (adv % 48 == 0);
            if ((e_mct && STEP_MODE) || ((adv % 4 == 0) && STOP)) halted = 1;
        end else if (!STEP_MODE && !STOP) begin
            halted = 0;
        end
        adv2++;
        e2_rt  = (adv2 % 3 == 0);
        e2_wt  = (adv2 % 3 == 1);
        e2_ct  = (adv2 % 3 == 2);
        e2_mct = (adv2 % 15 == 0);
    endtask

    task automatic take_snap();
        snap_phase = PHASE; snap_tp = TP; snap_rt = RT; snap_wt = WT;
        snap_ct = CT; snap_mct = MCT_END; snap_odd = ODDSET; snap_run = RUNNING;
    endtask

    // One CLOCK period; the outputs must respond exactly SYNC_STAGES+1 cycles after the rise.
    task automatic do_tick();
        @(negedge SIM_CLK) CLOCK = 1'b1;
        repeat (3) @(posedge SIM_CLK);
        #1;
        model_tick();
        check_all("tick", 1'b1);
        take_snap();
        @(posedge SIM_CLK);
        #1;
        check_all("post", 1'b0);
        @(negedge SIM_CLK) CLOCK = 1'b0;
        repeat (3) @(negedge SIM_CLK);
    endtask

    task automatic do_reset();
        @(negedge SIM_CLK);
        SIM_RST = 1'b1; STOP = 1'b0; STEP_MODE = 1'b0; MSTEP = 1'b0; CLOCK = 1'b0;
        adv = 0; adv2 = 0; halted = 0;
        @(posedge SIM_CLK);
        #1;
        check_all("reset", 1'b0);
        @(negedge SIM_CLK) SIM_RST = 1'b0;
        repeat (4) @(negedge SIM_CLK);
    endtask

    task automatic pulse_mstep(input string tag);
        @(negedge SIM_CLK) MSTEP = 1'b1;
        @(posedge SIM_CLK);
        #1;
        if (halted && STEP_MODE) halted = 0;
        chk({tag, ".RUNNING"}, int'(RUNNING), int'(!halted));
        @(negedge SIM_CLK) MSTEP = 1'b0;
    endtask

    initial begin
        int cnt;
        int mcts;

        vecs[0] = '{4'b0010, 12'h001, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{4'b0100, 12'h001, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{4'b1000, 12'h001, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{4'b0001, 12'h002, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{4'b0010, 12'h002, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{4'b0100, 12'h002, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{4'b1000, 12'h002, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{4'b0001, 12'h004, 1'b0, 1'b0, 1'b0};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_tick();
            chk($sformatf("vec%0d.PHASE", i), int'(snap_phase), int'(vecs[i].phase));
            chk($sformatf("vec%0d.TP", i),    int'(snap_tp),    int'(vecs[i].tp));
            chk($sformatf("vec%0d.RT", i),    int'(snap_rt),    int'(vecs[i].rt));
            chk($sformatf("vec%0d.WT", i),    int'(snap_wt),    int'(vecs[i].wt));
            chk($sformatf("vec%0d.CT", i),    int'(snap_ct),    int'(vecs[i].ct));
        end
        for (int i = 8; i < 96; i++) begin
            do_tick();
            if (i == 47) begin
                chk("mct48.MCT_END", int'(snap_mct), 1);
                chk("mct48.TP", int'(snap_tp), 1);
                chk("mct48.PHASE", int'(snap_phase), 1);
                chk("mct48.ODDSET", int'(snap_odd), 1);
            end
            if (i == 95) begin
                chk("mct96.MCT_END", int'(snap_mct), 1);
                chk("mct96.ODDSET", int'(snap_odd), 0);
            end
        end

        do_reset();
        repeat (4) do_tick();
        STOP = 1'b1;
        repeat (4) do_tick();
        chk("stop.TP", int'(snap_tp), 12'h004);
        chk("stop.PHASE", int'(snap_phase), 1);
        chk("stop.RUNNING", int'(snap_run), 0);
        do_tick();
        chk("stop_frozen.TP", int'(snap_tp), 12'h004);
        pulse_mstep("mstep_nostep");
        STOP = 1'b0;
        do_tick();
        chk("resume1.RUNNING", int'(snap_run), 1);
        chk("resume1.PHASE", int'(snap_phase), 1);
        do_tick();
        chk("resume2.PHASE", int'(snap_phase), 2);
        chk("resume2.RT", int'(snap_rt), 1);

        do_reset();
        STEP_MODE = 1'b1;
        repeat (48) do_tick();
        chk("step.RUNNING", int'(snap_run), 0);
        chk("step.MCT_END", int'(snap_mct), 1);
        repeat (2) do_tick();
        pulse_mstep("mstep_go");
        cnt = 0;
        mcts = 0;
        do begin
            do_tick();
            cnt++;
            if (snap_mct) mcts++;
            if (cnt == 10) pulse_mstep("mstep_ignored");
        end while (snap_run && cnt < 100);
        chk("step_count", cnt, 48);
        chk("step_mct", mcts, 1);
        STOP = 1'b1;
        pulse_mstep("mstep_stop_step");
        STOP = 1'b0;
        STEP_MODE = 1'b0;
        do_tick();

        do_reset();
        repeat (22) do_tick();
        @(negedge SIM_CLK) CLOCK = 1'b1;
        repeat (3) @(posedge SIM_CLK);
        #1;
        model_tick();
        check_all("pre_rst", 1'b1);
        chk("pre_rst.CT", int'(CT), 1);
        chk("pre_rst.TP", int'(TP), 12'h020);
        #2 SIM_RST = 1'b1;
        #1;
        adv = 0; adv2 = 0; halted = 0;
        check_all("rst_async", 1'b0);
        @(negedge SIM_CLK) SIM_RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge SIM_CLK);
            #1;
            check_all("clk_high", 1'b0);
        end
        @(negedge SIM_CLK) CLOCK = 1'b0;
        repeat (3) @(negedge SIM_CLK);
        do_tick();
        chk("after_rst.RT", int'(snap_rt), 1);
        chk("after_rst.PHASE", int'(snap_phase), 2);

        do_reset();
        for (int i = 0; i < 300; i++) begin
            STOP = ($urandom_range(3) == 0);
            if ($urandom_range(15) == 0) STEP_MODE = ~STEP_MODE;
            if ($urandom_range(4) == 0) pulse_mstep("rnd_mstep");
            do_tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
